// File: rtl/tlb_search_arbiter_if.sv
// ---------------------------------------------------------------------------
// tlb_search_arbiter_if
//
// Search port of the joint TLB array. The arbiter drives the lookup key
// (enable, VPN2, ASID); the TLB array returns hit, index and the matching
// entry combinationally in the same cycle that s_en is high.
//
// Parameters:
//   VPN2_W   virtual page-pair number width
//   ASID_W   address-space identifier width
//   IDX_W    TLB index width
//   ENTRY_W  width of one packed TLB entry
//
// Signals:
//   s_en     search enable (arbiter -> TLB)
//   s_vpn2   search VPN2   (arbiter -> TLB)
//   s_asid   search ASID   (arbiter -> TLB)
//   s_found  hit flag      (TLB -> arbiter)
//   s_index  hit index     (TLB -> arbiter)
//   s_entry  hit entry     (TLB -> arbiter)
//
// Modports: master = arbiter side, slave = TLB array side.
// ---------------------------------------------------------------------------
interface tlb_search_arbiter_if #(
  parameter int unsigned VPN2_W  = 19,
  parameter int unsigned ASID_W  = 8,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned ENTRY_W = 78
);
  logic               s_en;
  logic [VPN2_W-1:0]  s_vpn2;
  logic [ASID_W-1:0]  s_asid;
  logic               s_found;
  logic [IDX_W-1:0]   s_index;
  logic [ENTRY_W-1:0] s_entry;

  modport master (
    output s_en,
    output s_vpn2,
    output s_asid,
    input  s_found,
    input  s_index,
    input  s_entry
  );

  modport slave (
    input  s_en,
    input  s_vpn2,
    input  s_asid,
    output s_found,
    output s_index,
    output s_entry
  );
endinterface

// File: rtl/tlb_search_arbiter.sv
// ---------------------------------------------------------------------------
// tlb_search_arbiter
//
// Shares the single search port of the joint TLB among three requesters:
// the instruction-side TLB buffer (I), the data-side TLB buffer (D) and the
// CP0 TLBP probe (P). Each grant runs one SEARCH cycle on the TLB port and
// returns a one-cycle registered response pulse to its owner in RESP. The
// captured found/index/entry are shared by all requesters.
//
// Build option:
//   ARB_RR_EN  defined   -> I/D arbitration is round-robin (P still wins)
//              undefined -> fixed priority P > D > I, no pointer register
//
// Parameters:
//   VPN2_W, ASID_W, IDX_W, ENTRY_W  (see tlb_search_arbiter_if)
//
// Ports:
//   clk                    rising-edge clock
//   rst                    asynchronous reset, active low
//   i_req/i_vpn2           instruction-side request (level) and key
//   i_rsp_valid            instruction-side response pulse
//   d_req/d_vpn2           data-side request and key
//   d_rsp_valid            data-side response pulse
//   p_req/p_vpn2           TLBP probe request and EntryHi.VPN2
//   p_rsp_valid            probe response pulse
//   flush                  cancels in-flight I/D transactions
//   cp0_asid               EntryHi.ASID, passed straight to the search port
//   srch                   TLB search port (master modport)
//   rsp_found/index/entry  registered search result, held until next capture
// ---------------------------------------------------------------------------
module tlb_search_arbiter #(
  parameter int unsigned VPN2_W  = 19,
  parameter int unsigned ASID_W  = 8,
  parameter int unsigned IDX_W   = 4,
  parameter int unsigned ENTRY_W = 78
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                i_req,
  input  logic [VPN2_W-1:0]   i_vpn2,
  output logic                i_rsp_valid,

  input  logic                d_req,
  input  logic [VPN2_W-1:0]   d_vpn2,
  output logic                d_rsp_valid,

  input  logic                p_req,
  input  logic [VPN2_W-1:0]   p_vpn2,
  output logic                p_rsp_valid,

  input  logic                flush,
  input  logic [ASID_W-1:0]   cp0_asid,

  tlb_search_arbiter_if.master srch,

  output logic                rsp_found,
  output logic [IDX_W-1:0]    rsp_index,
  output logic [ENTRY_W-1:0]  rsp_entry
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I    = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;
  localparam logic [1:0] OWN_P    = 2'd3;

  // Probe always wins; between I and D the preference bit decides a tie.
  function automatic logic [1:0] pick_winner(input logic pend_i_f,
                                             input logic pend_d_f,
                                             input logic pend_p_f,
                                             input logic prefer_d);
    logic [1:0] w;
    w = OWN_NONE;
    if (pend_p_f)
      w = OWN_P;
    else if (pend_i_f && pend_d_f)
      w = prefer_d ? OWN_D : OWN_I;
    else if (pend_d_f)
      w = OWN_D;
    else if (pend_i_f)
      w = OWN_I;
    return w;
  endfunction

  // Response pulse vector ordered {P, D, I}.
  function automatic logic [2:0] owner_to_vld(input logic [1:0] own);
    logic [2:0] v;
    v = 3'b000;
    case (own)
      OWN_I:   v = 3'b001;
      OWN_D:   v = 3'b010;
      OWN_P:   v = 3'b100;
      default: v = 3'b000;
    endcase
    return v;
  endfunction

  state_t             state_q;
  logic [1:0]         owner_q;
  logic [VPN2_W-1:0]  vpn2_p1;
  logic               s_en_p1;
  logic [2:0]         vld_p2;
  logic               found_p2;
  logic [IDX_W-1:0]   index_p2;
  logic [ENTRY_W-1:0] entry_p2;

  logic               pend_i;
  logic               pend_d;
  logic               pend_p;
  logic               prefer_d;
  logic [1:0]         winner;
  logic [VPN2_W-1:0]  win_vpn2;
  logic               kill;

`ifdef ARB_RR_EN
  // 0 = I preferred on the next I/D tie, 1 = D preferred.
  logic               rr_pref_d_q;
  assign prefer_d = rr_pref_d_q;
`else
  assign prefer_d = 1'b1;
`endif

  // In RESP the current owner drops its req only on the following cycle,
  // so its still-high req must not be counted as a new request.
  always_comb begin
    pend_i = i_req;
    pend_d = d_req;
    pend_p = p_req;
    if (state_q == ST_RESP) begin
      case (owner_q)
        OWN_I:   pend_i = 1'b0;
        OWN_D:   pend_d = 1'b0;
        OWN_P:   pend_p = 1'b0;
        default: ;
      endcase
    end
  end

  assign winner = pick_winner(pend_i, pend_d, pend_p, prefer_d);

  always_comb begin
    win_vpn2 = vpn2_p1;
    case (winner)
      OWN_I:   win_vpn2 = i_vpn2;
      OWN_D:   win_vpn2 = d_vpn2;
      OWN_P:   win_vpn2 = p_vpn2;
      default: win_vpn2 = vpn2_p1;
    endcase
  end

  // Flush abandons only buffer-side transactions; a probe always completes.
  assign kill = flush && (state_q != ST_IDLE) &&
                ((owner_q == OWN_I) || (owner_q == OWN_D));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_NONE;
      vpn2_p1  <= '0;
      s_en_p1  <= 1'b0;
      vld_p2   <= 3'b000;
      found_p2 <= 1'b0;
      index_p2 <= '0;
      entry_p2 <= '0;
`ifdef ARB_RR_EN
      rr_pref_d_q <= 1'b0;
`endif
    end else begin
      s_en_p1 <= 1'b0;
      vld_p2  <= 3'b000;
      case (state_q)
        // ---- stage p0 -> p1: arbitrate and latch the winner's key ----
        ST_IDLE: begin
          if (winner != OWN_NONE) begin
            owner_q <= winner;
            vpn2_p1 <= win_vpn2;
            s_en_p1 <= 1'b1;
            state_q <= ST_SEARCH;
          end
        end

        // ---- stage p1 -> p2: capture the TLB result ----
        ST_SEARCH: begin
          if (kill) begin
            owner_q <= OWN_NONE;
            state_q <= ST_IDLE;
          end else begin
            found_p2 <= srch.s_found;
            index_p2 <= srch.s_index;
            entry_p2 <= srch.s_entry;
            vld_p2   <= owner_to_vld(owner_q);
            state_q  <= ST_RESP;
          end
        end

        // ---- stage p2: response delivered, chain the next grant ----
        ST_RESP: begin
          if (kill) begin
            owner_q <= OWN_NONE;
            state_q <= ST_IDLE;
          end else begin
`ifdef ARB_RR_EN
            if (owner_q == OWN_I)
              rr_pref_d_q <= 1'b1;
            else if (owner_q == OWN_D)
              rr_pref_d_q <= 1'b0;
`endif
            if (winner != OWN_NONE) begin
              owner_q <= winner;
              vpn2_p1 <= win_vpn2;
              s_en_p1 <= 1'b1;
              state_q <= ST_SEARCH;
            end else begin
              owner_q <= OWN_NONE;
              state_q <= ST_IDLE;
            end
          end
        end

        default: begin
          owner_q <= OWN_NONE;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign srch.s_en   = s_en_p1;
  assign srch.s_vpn2 = vpn2_p1;
  assign srch.s_asid = cp0_asid;

  // A flush landing in RESP suppresses an I/D pulse that was already
  // registered; the probe pulse is never masked.
  assign i_rsp_valid = vld_p2[0] & ~flush;
  assign d_rsp_valid = vld_p2[1] & ~flush;
  assign p_rsp_valid = vld_p2[2];

  assign rsp_found = found_p2;
  assign rsp_index = index_p2;
  assign rsp_entry = entry_p2;

endmodule

// File: tb/tb_tlb_search_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tlb_search_arbiter
//
// Directed-vector bench for tlb_search_arbiter. A small TLB array model
// answers the search port from a fixed table. Expected responses are queued
// when requests are issued; a monitor pops and compares on every response
// pulse. Timing-specific checks are made inline by the stimulus.
// ---------------------------------------------------------------------------
module tb_tlb_search_arbiter;
  localparam int unsigned VPN2_W  = 19;
  localparam int unsigned ASID_W  = 8;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned ENTRY_W = 78;

  localparam logic [1:0] W_I = 2'd1;
  localparam logic [1:0] W_D = 2'd2;
  localparam logic [1:0] W_P = 2'd3;

  localparam logic [ENTRY_W-1:0] ENT3  = 78'h0_0400_0512_3456_789A_BC;
  localparam logic [ENTRY_W-1:0] ENT7  = 78'h2_0555_0A9A_BCDE_F012_34;
  localparam logic [ENTRY_W-1:0] ENT12 = 78'h1_1234_0F00_DEAD_BEEF_55;

  typedef struct packed {
    logic [1:0]         who;
    logic               found;
    logic [IDX_W-1:0]   idx;
    logic [ENTRY_W-1:0] ent;
  } exp_t;

  logic               clk;
  logic               rst;
  logic               i_req, d_req, p_req;
  logic [VPN2_W-1:0]  i_vpn2, d_vpn2, p_vpn2;
  logic               i_rsp_valid, d_rsp_valid, p_rsp_valid;
  logic               flush;
  logic [ASID_W-1:0]  cp0_asid;
  logic               rsp_found;
  logic [IDX_W-1:0]   rsp_index;
  logic [ENTRY_W-1:0] rsp_entry;

  int   checks;
  int   errors;
  exp_t exp_q[$];

  tlb_search_arbiter_if #(
    .VPN2_W(VPN2_W), .ASID_W(ASID_W), .IDX_W(IDX_W), .ENTRY_W(ENTRY_W)
  ) sif ();

  tlb_search_arbiter #(
    .VPN2_W(VPN2_W), .ASID_W(ASID_W), .IDX_W(IDX_W), .ENTRY_W(ENTRY_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req       (i_req),
    .i_vpn2      (i_vpn2),
    .i_rsp_valid (i_rsp_valid),
    .d_req       (d_req),
    .d_vpn2      (d_vpn2),
    .d_rsp_valid (d_rsp_valid),
    .p_req       (p_req),
    .p_vpn2      (p_vpn2),
    .p_rsp_valid (p_rsp_valid),
    .flush       (flush),
    .cp0_asid    (cp0_asid),
    .srch        (sif.master),
    .rsp_found   (rsp_found),
    .rsp_index   (rsp_index),
    .rsp_entry   (rsp_entry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // TLB array model: three resident pages, everything else misses.
  always_comb begin
    sif.s_found = 1'b0;
    sif.s_index = '0;
    sif.s_entry = '0;
    case (sif.s_vpn2)
      19'h00400: begin sif.s_found = 1'b1; sif.s_index = 4'd3;  sif.s_entry = ENT3;  end
      19'h00555: begin sif.s_found = 1'b1; sif.s_index = 4'd7;  sif.s_entry = ENT7;  end
      19'h01234: begin sif.s_found = 1'b1; sif.s_index = 4'd12; sif.s_entry = ENT12; end
      default:   ;
    endcase
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] who, input logic found,
                      input logic [IDX_W-1:0] idx, input logic [ENTRY_W-1:0] ent);
    exp_t e;
    e.who   = who;
    e.found = found;
    e.idx   = idx;
    e.ent   = ent;
    exp_q.push_back(e);
  endtask

  // Runs cycles, releasing each req once its response is seen, until no
  // request is left high or the cycle budget runs out.
  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while ((i_req || d_req || p_req) && (n < max_cycles)) begin
      tick();
      n++;
      if (i_rsp_valid) i_req = 1'b0;
      if (d_rsp_valid) d_req = 1'b0;
      if (p_rsp_valid) p_req = 1'b0;
    end
    check("drain_reqs_left", 128'({p_req, d_req, i_req}), 128'(0));
    i_req = 1'b0;
    d_req = 1'b0;
    p_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic monitor();
    exp_t       e;
    logic [1:0] who;
    forever begin
      @(negedge clk);
      if (rst && (i_rsp_valid || d_rsp_valid || p_rsp_valid)) begin
        check("rsp_onehot", 128'($countones({p_rsp_valid, d_rsp_valid, i_rsp_valid})), 128'(1));
        who = p_rsp_valid ? W_P : (d_rsp_valid ? W_D : W_I);
        if (exp_q.size() == 0) begin
          check("rsp_unexpected_owner", 128'(who), 128'(0));
        end else begin
          e = exp_q.pop_front();
          check("rsp_owner", 128'(who),       128'(e.who));
          check("rsp_found", 128'(rsp_found), 128'(e.found));
          check("rsp_index", 128'(rsp_index), 128'(e.idx));
          check("rsp_entry", 128'(rsp_entry), 128'(e.ent));
        end
      end
    end
  endtask

  task automatic run_tests();
    // Reset state
    tick();
    check("rst_s_en",    128'(sif.s_en),    128'(0));
    check("rst_valids",  128'({p_rsp_valid, d_rsp_valid, i_rsp_valid}), 128'(0));
    check("rst_found",   128'(rsp_found),   128'(0));
    check("rst_index",   128'(rsp_index),   128'(0));
    check("rst_entry",   128'(rsp_entry),   128'(0));
    check("rst_s_vpn2",  128'(sif.s_vpn2),  128'(0));
    check("rst_s_asid",  128'(sif.s_asid),  128'(8'h05));
    rst = 1'b1;
    tick();

    // Single I hit: s_en at N+1, response at N+2
    i_req = 1'b1; i_vpn2 = 19'h00400;
    push(W_I, 1'b1, 4'd3, ENT3);
    tick();
    check("t1_s_en",   128'(sif.s_en),    128'(1));
    check("t1_s_vpn2", 128'(sif.s_vpn2),  128'(19'h00400));
    check("t1_s_asid", 128'(sif.s_asid),  128'(8'h05));
    check("t1_no_rsp", 128'(i_rsp_valid), 128'(0));
    tick();
    check("t1_i_rsp",  128'(i_rsp_valid), 128'(1));
    check("t1_found",  128'(rsp_found),   128'(1));
    check("t1_index",  128'(rsp_index),   128'(3));
    check("t1_s_en_off", 128'(sif.s_en),  128'(0));
    i_req = 1'b0;
    tick();
    check("t1_idle_s_en", 128'(sif.s_en), 128'(0));
    check("t1_hold_vpn2", 128'(sif.s_vpn2), 128'(19'h00400));
    tick();

    // All three at once after I was served: P, then D, then I
    i_req = 1'b1; i_vpn2 = 19'h00400;
    d_req = 1'b1; d_vpn2 = 19'h00555;
    p_req = 1'b1; p_vpn2 = 19'h01234;
    push(W_P, 1'b1, 4'd12, ENT12);
    push(W_D, 1'b1, 4'd7,  ENT7);
    push(W_I, 1'b1, 4'd3,  ENT3);
    tick();
    check("t2_s_vpn2_p", 128'(sif.s_vpn2), 128'(19'h01234));
    tick();
    check("t2_p_rsp_c2", 128'(p_rsp_valid), 128'(1));
    p_req = 1'b0;
    tick();
    check("t2_s_en_d",   128'(sif.s_en),   128'(1));
    check("t2_s_vpn2_d", 128'(sif.s_vpn2), 128'(19'h00555));
    tick();
    check("t2_d_rsp_c4", 128'(d_rsp_valid), 128'(1));
    d_req = 1'b0;
    tick();
    check("t2_s_vpn2_i", 128'(sif.s_vpn2), 128'(19'h00400));
    tick();
    check("t2_i_rsp_c6", 128'(i_rsp_valid), 128'(1));
    i_req = 1'b0;
    tick();
    tick();

    // D miss
    d_req = 1'b1; d_vpn2 = 19'h7ffff;
    push(W_D, 1'b0, 4'd0, '0);
    drain(10);

    // D flushed in SEARCH, re-granted because d_req stays high
    d_req = 1'b1; d_vpn2 = 19'h00555;
    tick();
    check("t4_s_en", 128'(sif.s_en), 128'(1));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t4_no_d_rsp", 128'(d_rsp_valid), 128'(0));
    check("t4_idle_s_en", 128'(sif.s_en), 128'(0));
    push(W_D, 1'b1, 4'd7, ENT7);
    tick();
    check("t4_regrant_s_en", 128'(sif.s_en), 128'(1));
    tick();
    check("t4_d_rsp", 128'(d_rsp_valid), 128'(1));
    d_req = 1'b0;
    tick();
    tick();

    // D flushed in RESP: pulse suppressed, nothing follows
    d_req = 1'b1; d_vpn2 = 19'h00400;
    tick();
    tick();
    flush = 1'b1;
    d_req = 1'b0;
    #1;
    check("t5_rsp_masked", 128'(d_rsp_valid), 128'(0));
    tick();
    flush = 1'b0;
    check("t5_s_en", 128'(sif.s_en), 128'(0));
    tick();
    check("t5_no_regrant", 128'(sif.s_en), 128'(0));

    // P flushed in SEARCH still completes
    cp0_asid = 8'h3C;
    p_req = 1'b1; p_vpn2 = 19'h01234;
    push(W_P, 1'b1, 4'd12, ENT12);
    tick();
    check("t6_s_asid", 128'(sif.s_asid), 128'(8'h3C));
    flush = 1'b1;
    tick();
    check("t6_p_rsp", 128'(p_rsp_valid), 128'(1));
    flush = 1'b0;
    p_req = 1'b0;
    tick();
    tick();

    // I and D together from IDLE
    i_req = 1'b1; i_vpn2 = 19'h01234;
    d_req = 1'b1; d_vpn2 = 19'h00555;
`ifdef ARB_RR_EN
    // Last I/D service was D, so I is preferred.
    push(W_I, 1'b1, 4'd12, ENT12);
    push(W_D, 1'b1, 4'd7,  ENT7);
`else
    push(W_D, 1'b1, 4'd7,  ENT7);
    push(W_I, 1'b1, 4'd12, ENT12);
`endif
    drain(20);

    // Asynchronous reset during RESP
    i_req = 1'b1; i_vpn2 = 19'h00400;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("t8_valid_drop", 128'({p_rsp_valid, d_rsp_valid, i_rsp_valid}), 128'(0));
    check("t8_s_en",       128'(sif.s_en),  128'(0));
    check("t8_found_now",  128'(rsp_found), 128'(0));
    i_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("t8_found", 128'(rsp_found),  128'(0));
    check("t8_index", 128'(rsp_index),  128'(0));
    check("t8_vpn2",  128'(sif.s_vpn2), 128'(0));

    // Recovery after reset
    i_req = 1'b1; i_vpn2 = 19'h00555;
    push(W_I, 1'b1, 4'd7, ENT7);
    drain(10);

    check("queue_empty", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    i_req    = 1'b0; d_req = 1'b0; p_req = 1'b0;
    i_vpn2   = '0;   d_vpn2 = '0;  p_vpn2 = '0;
    flush    = 1'b0;
    cp0_asid = 8'h05;
    fork
      monitor();
      run_tests();
    join_any
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tlb_search_arbiter.md
# tlb_search_arbiter

Shares the single search port of the joint TLB among three requesters: the instruction-side TLB buffer (refill on buffer miss), the data-side TLB buffer, and the CP0 TLBP probe. It is a small FSM plus arbitration logic that sits between the two TLB buffers, CP0, and the TLB array. Each granted request runs one search cycle and returns one registered response pulse. The search port drives the ASID and VPN2 and captures found, index and entry.

## Interface
Parameters:
- VPN2_W, 19, virtual page-pair number width (vaddr[31:13])
- ASID_W, 8, ASID width
- IDX_W, 4, TLB index width (16 entries)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- i_req  in  1  instruction-side search request, level; held until i_rsp_valid
- i_vpn2  in  VPN2_W  instruction-side VPN2; stable while i_req
- i_rsp_valid  out  1  one-cycle response pulse to instruction side
- d_req  in  1  data-side search request, level
- d_vpn2  in  VPN2_W  data-side VPN2
- d_rsp_valid  out  1  one-cycle response pulse to data side
- p_req  in  1  TLBP probe request, level
- p_vpn2  in  VPN2_W  EntryHi.VPN2 for probe
- p_rsp_valid  out  1  one-cycle response pulse to CP0
- flush  in  1  pipeline / TLB-buffer flush; cancels I and D transactions
- cp0_asid  in  ASID_W  EntryHi.ASID
- s_en  out  1  search port enable
- s_vpn2  out  VPN2_W  search port VPN2
- s_asid  out  ASID_W  search port ASID
- s_found  in  1  TLB hit, combinational on the same cycle as s_en
- s_index  in  IDX_W  matching index
- s_entry  in  TLB_Entry  matching entry
- rsp_found  out  1  registered found; shared by all requesters
- rsp_index  out  IDX_W  registered index
- rsp_entry  out  TLB_Entry  registered entry

## Operation
- States: IDLE, SEARCH, RESP. A 2-bit owner register (NONE/I/D/P) records the granted requester.
- **IDLE**
  - With any req pending: pick a winner, latch owner and the winner's VPN2, and go to SEARCH.
  - With no req pending: stay in IDLE.
- **Arbitration**
  - P always wins.
  - Between I and D: round-robin if ARB_RR_EN is defined, otherwise fixed priority.
- **SEARCH**
  - Drive s_en=1, s_vpn2 from the latched VPN2, and s_asid=cp0_asid.
  - At the clock edge, capture s_found, s_index and s_entry into the rsp_* registers, then go to RESP.
- **RESP**
  - Assert the owner's *_rsp_valid for exactly one cycle.
  - Next state: if another request is pending, go directly to SEARCH with the new winner; otherwise go to IDLE.
  - The requester that owns the current response is masked out of the pending set in this cycle, because it drops req one cycle later.
- **Flush**
  - In SEARCH or RESP, with owner I or D: no rsp_valid is asserted, the transaction is abandoned, owner clears to NONE, and the FSM goes to IDLE.
  - A P transaction is never cancelled by flush.
  - In IDLE, flush has no effect; reqs remaining high after flush are arbitrated normally.
- **Outputs**
  - s_en=0 outside SEARCH.
  - s_vpn2 and s_asid hold their last values when idle.
  - The rsp_* registers hold their values until the next capture.

## Timing
- **Reset values:** state=IDLE, owner=NONE, RR pointer=I-preferred, all *_rsp_valid=0, s_en=0, s_vpn2=0, s_asid=cp0_asid (combinational), rsp_found=0, rsp_index=0, rsp_entry='0.
- **Reset mid-transaction:** asserting rst in SEARCH or RESP forces all of the above immediately (asynchronously); no rsp pulse is generated.
- **Latency:** req sampled in IDLE at cycle N → s_en in N+1 → *_rsp_valid in N+2.
- **Back-to-back:** throughput is one search every 2 cycles (SEARCH, RESP, SEARCH, ...).
- **Simultaneous events:**
  - p_req, d_req and i_req all rising in the same cycle are served in the order P, then D/I per policy.
  - flush together with p ownership: the P transaction completes normally.
- **Handshake rule:** each req must stay high and its VPN2 stable until its rsp_valid. A req dropped before its grant is simply not served.

## Configuration
- ARB_RR_EN defined: I/D fairness is round-robin.
  - After I is served, D is preferred; after D is served, I is preferred.
  - P grants do not move the pointer.
- ARB_RR_EN undefined: fixed priority P > D > I.
  - The RR pointer register is removed.

## Test plan
- i_req=1, i_vpn2=19'h00400, cp0_asid=8'h05, TLB hit at index 3:
  - s_en=1 at N+1 with s_vpn2=19'h00400 and s_asid=8'h05.
  - At N+2: i_rsp_valid=1, rsp_found=1, rsp_index=4'd3.
- i_req, d_req and p_req all high at cycle 0 (ARB_RR_EN):
  - p_rsp_valid at cycle 2, then d_rsp_valid at 4 and i_rsp_valid at 6 (RR pointer at reset prefers I, but D wins here only if pointer=D; bench preloads the pointer by serving I first, then asserts all three, expecting P, D, I).
- d_req granted, flush=1 during SEARCH:
  - No d_rsp_valid.
  - FSM back in IDLE the next cycle.
  - d_req still high is re-granted, with s_en 2 cycles after flush.
- p_req granted, flush=1 during SEARCH: p_rsp_valid still pulses at N+2.
- Without ARB_RR_EN, i_req and d_req held high continuously with d re-requesting immediately: D is served each time while pending; I is served only in gaps.
- rst=0 asserted during RESP: all *_rsp_valid drop within the same cycle (asynchronous); after release, state=IDLE and rsp_found=0.
